fetch_unit: RTL

- Instruction-fetch (IF) stage of the 5-stage pipeline; consumes the hazard unit's Stall/Flush (listener side) and the EX-stage redirect target.
- Owns the PC and a single-outstanding-request instruction-memory handshake with variable latency.
- Drives the IF/ID pipeline register into the ID stage; a one-entry skid buffer absorbs responses that arrive while the pipeline is stalled.

---
 rtl/fetch_unit_pkg.sv | 19 +
 rtl/fetch_unit_skid_buffer.sv | 32 +++
 rtl/fetch_unit.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared IF-stage types: fetch FSM states, bubble encoding, IF/ID bundle.
package fetch_unit_pkg;

    localparam int          XLEN      = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_HOLD
    } fetch_state_t;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } if_id_t;

endpackage

// File: rtl/fetch_unit_skid_buffer.sv
// One-entry {pc, instr} park register for responses arriving under Stall.
module fetch_skid_buffer
    import fetch_unit_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] load_pc,
    input  logic [W-1:0] load_instr,
    output logic         full,
    output logic [W-1:0] pc,
    output logic [W-1:0] instr
);

    always_ff @(posedge clk) begin
        if (rst) begin
            full  <= 1'b0;
            pc    <= '0;
            instr <= '0;
        end else if (clear) begin
            full <= 1'b0;
        end else if (load) begin
            full  <= 1'b1;
            pc    <= load_pc;
            instr <= load_instr;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// IF stage: owns the PC, one outstanding imem request, and the IF/ID register.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int               XLEN      = 32,
    parameter logic [XLEN-1:0]  RESET_PC  = 32'h0000_0000,
    parameter logic [XLEN-1:0]  NOP_INSTR = fetch_unit_pkg::NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            Stall,
    input  logic            Flush,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            id_valid,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_instr
);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] fetch_pc_q;
    logic            discard_q, discard_d;
    logic            latch_fetch;
    if_id_t          if_id_q, if_id_d;

    logic            deliver;
    logic [XLEN-1:0] dlv_pc, dlv_instr;

    logic            skid_load, skid_clear, skid_full;
    logic [XLEN-1:0] skid_pc, skid_instr;

    logic            unused_redirect_lsb;

    assign unused_redirect_lsb = ^redirect_pc[1:0];

    assign imem_req  = !rst && (state_q == S_REQ);
    assign imem_addr = pc_q;

    fetch_skid_buffer #(.W(XLEN)) u_skid (
        .clk        (clk),
        .rst        (rst),
        .load       (skid_load),
        .clear      (skid_clear),
        .load_pc    (fetch_pc_q),
        .load_instr (imem_rdata),
        .full       (skid_full),
        .pc         (skid_pc),
        .instr      (skid_instr)
    );

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        discard_d   = discard_q;
        latch_fetch = 1'b0;
        skid_load   = 1'b0;
        skid_clear  = Flush;
        deliver     = 1'b0;
        dlv_pc      = fetch_pc_q;
        dlv_instr   = imem_rdata;

        unique case (state_q)
            S_REQ: begin
                if (imem_req && imem_gnt) begin
                    state_d     = S_WAIT;
                    latch_fetch = 1'b1;
                    discard_d   = Flush;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    state_d   = S_REQ;
                    discard_d = 1'b0;
                    // A killed fetch leaves pc on the redirect target.
                    if (!discard_q && !Flush) begin
                        pc_d = fetch_pc_q + XLEN'(4);
                        if (Stall) begin
                            skid_load = 1'b1;
                            state_d   = S_HOLD;
                        end else begin
                            deliver = 1'b1;
                        end
                    end
                end else if (Flush) begin
                    discard_d = 1'b1;
                end
            end
            S_HOLD: begin
                if (Flush) begin
                    state_d = S_REQ;
                end else if (!Stall) begin
                    state_d    = S_REQ;
                    skid_clear = 1'b1;
                    deliver    = skid_full;
                    dlv_pc     = skid_pc;
                    dlv_instr  = skid_instr;
                end
            end
            default: state_d = S_REQ;
        endcase

        if (Flush) begin
            pc_d = {redirect_pc[XLEN-1:2], 2'b00};
        end

        if_id_d = if_id_q;
        if (Flush || (!Stall && !deliver)) begin
            if_id_d.valid = 1'b0;
            if_id_d.instr = NOP_INSTR;
        end else if (!Stall) begin
            if_id_d.valid = 1'b1;
            if_id_d.pc    = dlv_pc;
            if_id_d.instr = dlv_instr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_REQ;
            pc_q       <= RESET_PC;
            fetch_pc_q <= '0;
            discard_q  <= 1'b0;
            if_id_q    <= '{valid: 1'b0, pc: '0, instr: NOP_INSTR};
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            discard_q <= discard_d;
            if_id_q   <= if_id_d;
            if (latch_fetch) begin
                fetch_pc_q <= pc_q;
            end
        end
    end

    assign id_valid = if_id_q.valid;
    assign id_pc    = if_id_q.pc;
    assign id_instr = if_id_q.instr;

endmodule
